// File: rtl/serial_pattern_source.sv
// Framed, handshaked serial source feeding the sequence-detector FSM: loads a pattern word and
// shifts eff_len bits out on w, MSB-of-field first. Define SERIAL_GAP_EN for an idle gap after each frame.
module serial_pattern_source #(
  parameter int WIDTH      = 8,
  parameter int LEN_W      = 4,
  parameter int GAP_CYCLES = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done
);

  if (2**LEN_W <= WIDTH || GAP_CYCLES < 0) begin : g_bad_cfg
    $error("serial_pattern_source: LEN_W too narrow for WIDTH, or negative GAP_CYCLES");
  end

`ifdef SERIAL_GAP_EN
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GAP_W-1:0] gap_q;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_e;
`endif

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [LEN_W-1:0] cnt_q;
  logic             w_q, w_valid_q, done_q;

  logic [LEN_W-1:0] eff_len;
  logic [WIDTH-1:0] aligned;
  logic             last_bit, accept;

  // NOTE: every signal gets a value on every path through always_comb, otherwise a latch is inferred.
  always_comb begin
    eff_len  = (load_len == '0 || load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : load_len;
    aligned  = load_data << (WIDTH - int'(eff_len));
    last_bit = (state_q == SHIFT) && (cnt_q == '0);
`ifdef SERIAL_GAP_EN
    load_ready = reset && (state_q == IDLE);
`else
    load_ready = reset && ((state_q == IDLE) || last_bit);
`endif
    accept = load_valid && load_ready;
  end

  // cnt_q counts the bits still to come after the one currently on w.
  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef SERIAL_GAP_EN
      gap_q     <= '0;
`endif
    end else if (accept) begin
      state_q   <= SHIFT;
      w_q       <= aligned[WIDTH-1];
      shreg_q   <= aligned << 1;
      cnt_q     <= eff_len - 1'b1;
      w_valid_q <= 1'b1;
      done_q    <= (eff_len == LEN_W'(1));
    end else begin
      case (state_q)
        SHIFT: begin
          if (cnt_q == '0) begin
            w_q       <= 1'b0;
            w_valid_q <= 1'b0;
            done_q    <= 1'b0;
            shreg_q   <= '0;
`ifdef SERIAL_GAP_EN
            if (GAP_CYCLES > 0) begin
              state_q <= GAP;
              gap_q   <= GAP_W'(GAP_CYCLES - 1);
            end else begin
              state_q <= IDLE;
            end
`else
            state_q   <= IDLE;
`endif
          end else begin
            w_q     <= shreg_q[WIDTH-1];
            shreg_q <= shreg_q << 1;
            cnt_q   <= cnt_q - 1'b1;
            done_q  <= (cnt_q == LEN_W'(1));
          end
        end
`ifdef SERIAL_GAP_EN
        GAP: begin
          if (gap_q == '0) state_q <= IDLE;
          else             gap_q   <= gap_q - 1'b1;
        end
`endif
        default: begin
          state_q   <= IDLE;
          w_q       <= 1'b0;
          w_valid_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign w       = w_q;
  assign w_valid = w_valid_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_serial_pattern_source.sv
// Scoreboard bench for serial_pattern_source: accepted frames push expected bits, a negedge
// monitor pops and compares them; directed steps cover reset, framing, clamping, gaps and stalls.
module tb_serial_pattern_source;

  localparam int WIDTH = 8;
  localparam int LEN_W = 4;
`ifdef SERIAL_GAP_EN
  localparam int GAP_EXP = 3;
`else
  localparam int GAP_EXP = 0;
`endif

  typedef struct {
    logic w;
    logic last;
  } exp_bit_t;

  logic             clock = 1'b0;
  logic             reset;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;
  logic             w, w_valid, busy, done;

  exp_bit_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  serial_pattern_source #(.WIDTH(WIDTH), .LEN_W(LEN_W), .GAP_CYCLES(3)) dut (
    .clock(clock), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_len(load_len),
    .w(w), .w_valid(w_valid), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [WIDTH-1:0] data, input logic [LEN_W-1:0] len);
    int eff;
    eff = (len == 0 || len > WIDTH) ? WIDTH : int'(len);
    for (int i = eff - 1; i >= 0; i--) exp_q.push_back('{w: data[i], last: (i == 0)});
  endtask

  // Offer a frame, wait (bounded) for ready, and scramble the inputs once it is accepted.
  task automatic offer(input logic [WIDTH-1:0] data, input logic [LEN_W-1:0] len, output int waited);
    @(negedge clock);
    load_data  = data;
    load_len   = len;
    load_valid = 1'b1;
    waited     = 0;
    while (!load_ready && waited < 60) begin
      @(negedge clock);
      waited++;
    end
    check("ready_timeout", {31'd0, load_ready}, 32'd1);
    if (load_ready) begin
      @(posedge clock);
      #1;
      push_frame(data, len);
      load_valid = 1'b0;
      load_data  = ~data;
      load_len   = LEN_W'($urandom);
    end else begin
      load_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clock);
    while (!done && n < 60) begin
      @(negedge clock);
      n++;
    end
    check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  // Scoreboard monitor: frame bits while the queue holds any, idle zeros otherwise.
  always @(negedge clock) begin
    exp_bit_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("w_valid", {31'd0, w_valid}, 32'd1);
      check("w_bit",   {31'd0, w},       {31'd0, e.w});
      check("done",    {31'd0, done},    {31'd0, e.last});
    end else begin
      check("idle_w_valid", {31'd0, w_valid}, 32'd0);
      check("idle_w",       {31'd0, w},       32'd0);
      check("idle_done",    {31'd0, done},    32'd0);
    end
  end

  initial begin
    int wt, g;
    reset      = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'hFF;
    load_len   = 4'd3;

    // Reset held with a frame offered.
    repeat (3) @(negedge clock);
    check("rst_ready",   {31'd0, load_ready}, 32'd0);
    check("rst_w",       {31'd0, w},          32'd0);
    check("rst_w_valid", {31'd0, w_valid},    32'd0);
    check("rst_done",    {31'd0, done},       32'd0);
    check("rst_busy",    {31'd0, busy},       32'd0);
    load_valid = 1'b0;
    reset      = 1'b1;
    @(negedge clock);
    check("post_rst_ready", {31'd0, load_ready}, 32'd1);

    // Single 3-bit frame, accepted straight from IDLE.
    offer(8'b0000_0010, 4'd3, wt);
    check("idle_accept_wait", wt, 0);
    drain();

    // Two frames offered back to back; ready returns on the last bit or after the gap.
    offer(8'b0000_1101, 4'd4, wt);
    offer(8'b0001_1101, 4'd5, wt);
    check("b2b_wait", wt, 3 + ((GAP_EXP > 0) ? GAP_EXP + 1 : 0));
    wait_done();
    g = 0;
    @(negedge clock);
    while (busy && g < 20) begin
      check("gap_w", {31'd0, w}, 32'd0);
      g++;
      @(negedge clock);
    end
    check("gap_len", g, GAP_EXP);
    drain();

    // Length clamping.
    offer(8'hA5, 4'd0, wt);
    drain();
    offer(8'hA5, 4'd12, wt);
    drain();
    offer(8'h01, 4'd1, wt);
    drain();

    // Reset during the second bit of a 4-bit frame.
    offer(8'b0000_0110, 4'd4, wt);
    @(negedge clock);
    @(negedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_w",       {31'd0, w},          32'd0);
    check("mid_rst_w_valid", {31'd0, w_valid},    32'd0);
    check("mid_rst_busy",    {31'd0, busy},       32'd0);
    check("mid_rst_done",    {31'd0, done},       32'd0);
    check("mid_rst_ready",   {31'd0, load_ready}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("post_abort_busy", {31'd0, busy}, 32'd0);
    end

    // Stall in IDLE with garbage on the data inputs.
    repeat (5) begin
      load_data = WIDTH'($urandom);
      @(negedge clock);
      check("stall_w",    {31'd0, w},    32'd0);
      check("stall_busy", {31'd0, busy}, 32'd0);
    end

    // Random frames issued as fast as the block accepts them.
    for (int k = 0; k < 6; k++) offer(WIDTH'($urandom), LEN_W'($urandom_range(0, 15)), wt);
    drain();
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
